trig_clk_div: RTL and testbench

//   Multi-channel, trigger-armed clock divider. Each channel waits for a selectable

---
 rtl/trig_clk_div.sv | 144 ++++++++++++++
 tb/tb_trig_clk_div.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_clk_div.sv
// Multi-channel, trigger-armed 50% duty clock divider with optional burst length.
// Define TRIG_CLK_DIV_RETRIG_EN to let a trigger edge restart a channel that is already running.
module trig_clk_div #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 8,
    parameter int unsigned BW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              Clk_24M,
    input  logic              Rst,
    input  logic [NCH-1:0]    trig,
    input  logic [NCH-1:0]    fall_sel,
    input  logic [NCH*CW-1:0] half_per,
    input  logic [NCH*BW-1:0] burst,
    input  logic [NCH-1:0]    disarm,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  hp_q    [NCH];
    logic [CW-1:0]  hp_d    [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [BW-1:0]  bc_q    [NCH];
    logic [BW-1:0]  bc_d    [NCH];
    logic [BW-1:0]  pcnt_q  [NCH];
    logic [BW-1:0]  pcnt_d  [NCH];
    logic [NCH-1:0] sync_q  [SYNC_STAGES];
    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] sync_last_c, edge_c, retrig_c, load_c;

    assign sync_last_c = sync_q[SYNC_STAGES-1];
    assign edge_c = (fall_sel & ~sync_last_c & prev_q) | (~fall_sel & sync_last_c & ~prev_q);

`ifdef TRIG_CLK_DIV_RETRIG_EN
    assign retrig_c = edge_c;
`else
    assign retrig_c = '0;
`endif

    // State and trigger pipeline registers
    always_ff @(posedge Clk_24M) begin
        if (Rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            clk_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                hp_q[i]    <= '0;
                cnt_q[i]   <= '0;
                bc_q[i]    <= '0;
                pcnt_q[i]  <= '0;
            end
        end else begin
            sync_q[0] <= trig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_last_c;
            clk_q  <= clk_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                hp_q[i]    <= hp_d[i];
                cnt_q[i]   <= cnt_d[i];
                bc_q[i]    <= bc_d[i];
                pcnt_q[i]  <= pcnt_d[i];
            end
        end
    end

    // Per-channel next state; disarm outranks arming and retriggering
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            hp_d[i]    = hp_q[i];
            cnt_d[i]   = cnt_q[i];
            bc_d[i]    = bc_q[i];
            pcnt_d[i]  = pcnt_q[i];
            clk_d[i]   = clk_q[i];
            done_d[i]  = 1'b0;
            load_c[i]  = 1'b0;

            if (disarm[i]) begin
                state_d[i] = IDLE;
                clk_d[i]   = 1'b0;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: load_c[i] = edge_c[i];
                    RUN: begin
                        if (retrig_c[i]) begin
                            load_c[i] = 1'b1;
                        end else if (cnt_q[i] == hp_q[i] - CW'(1)) begin
                            cnt_d[i] = '0;
                            clk_d[i] = ~clk_q[i];
                            if (clk_q[i]) begin
                                pcnt_d[i] = pcnt_q[i] + BW'(1);
                                if ((bc_q[i] != '0) && (pcnt_q[i] + BW'(1) == bc_q[i])) begin
                                    done_d[i]  = 1'b1;
                                    state_d[i] = IDLE;
                                end
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                endcase
            end

            // half_per of zero runs as one, i.e. Clk_24M/2
            if (load_c[i]) begin
                state_d[i] = RUN;
                hp_d[i]    = (half_per[i*CW +: CW] == '0) ? CW'(1) : half_per[i*CW +: CW];
                bc_d[i]    = burst[i*BW +: BW];
                cnt_d[i]   = '0;
                pcnt_d[i]  = '0;
                clk_d[i]   = 1'b0;
            end

            busy_d[i] = (state_d[i] == RUN);
        end
    end

    assign clk_out = clk_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_trig_clk_div.sv
// Randomised and directed bench for trig_clk_div against a cycle-count reference model.
module tb_trig_clk_div;
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned BW  = 8;
    localparam int unsigned S   = 2;
`ifdef TRIG_CLK_DIV_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    trig, fall_sel, disarm;
    logic [NCH*CW-1:0] half_per;
    logic [NCH*BW-1:0] burst;
    logic [NCH-1:0]    clk_out, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trig_clk_div #(.NCH(NCH), .CW(CW), .BW(BW), .SYNC_STAGES(S)) dut (
        .Clk_24M (clk),
        .Rst     (rst),
        .trig    (trig),
        .fall_sel(fall_sel),
        .half_per(half_per),
        .burst   (burst),
        .disarm  (disarm),
        .clk_out (clk_out),
        .busy    (busy),
        .done    (done)
    );

    // Reference: trigger seen S cycles late; once armed, output follows elapsed cycles k:
    // high when (k / hp) is odd, burst ends when k reaches 2*hp*burst.
    logic [NCH-1:0] exp_clk = '0, exp_busy = '0, exp_done = '0;
    bit m_run  [NCH];
    int m_k    [NCH];
    int m_hp   [NCH];
    int m_bc   [NCH];
    bit m_hist [NCH][S+1];

    always @(posedge clk) begin : ref_model
        bit det;
        int hp_in;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_run[c] = 1'b0;
                m_k[c]   = 0;
                for (int j = 0; j <= S; j++) m_hist[c][j] = 1'b0;
                exp_clk[c]  = 1'b0;
                exp_busy[c] = 1'b0;
                exp_done[c] = 1'b0;
            end else begin
                det = fall_sel[c] ? (!m_hist[c][S-1] && m_hist[c][S])
                                  : (m_hist[c][S-1] && !m_hist[c][S]);
                for (int j = S; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
                m_hist[c][0] = trig[c];
                exp_done[c] = 1'b0;
                if (disarm[c]) begin
                    m_run[c]   = 1'b0;
                    exp_clk[c] = 1'b0;
                end else if (det && (!m_run[c] || RETRIG)) begin
                    hp_in      = int'(half_per[c*CW +: CW]);
                    m_hp[c]    = (hp_in == 0) ? 1 : hp_in;
                    m_bc[c]    = int'(burst[c*BW +: BW]);
                    m_k[c]     = 0;
                    m_run[c]   = 1'b1;
                    exp_clk[c] = 1'b0;
                end else if (m_run[c]) begin
                    m_k[c]++;
                    if (m_bc[c] != 0 && m_k[c] == 2 * m_hp[c] * m_bc[c]) begin
                        m_run[c]    = 1'b0;
                        exp_done[c] = 1'b1;
                        exp_clk[c]  = 1'b0;
                    end else begin
                        exp_clk[c] = ((m_k[c] / m_hp[c]) % 2) == 1;
                    end
                end
                exp_busy[c] = m_run[c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        trig     = '0;
        fall_sel = '0;
        half_per = '0;
        burst    = '0;
        disarm   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        trig     = '1;
        fall_sel = '0;
        disarm   = '0;
        burst    = '0;
        for (int c = 0; c < NCH; c++) half_per[c*CW +: CW] = CW'(3);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({clk_out, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs n=%0d got clk=%b busy=%b done=%b exp all 0", n, clk_out, busy, done);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (busy !== ((n >= 2) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_held_trig n=%0d got busy=%b exp %b", n, busy, (n >= 2) ? 4'hF : 4'h0);
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reset_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_continuous();
        logic e;
        apply_reset();
        half_per[0 +: CW] = CW'(5);
        trig[0] = 1'b1;
        for (int n = 0; n < 210; n++) begin
            tick();
            e = (n >= 7) && (((n - 7) / 5) % 2 == 0);
            checks++;
            if (clk_out[0] !== e) begin
                errors++;
                $display("FAIL cont_clk n=%0d got %b exp %b", n, clk_out[0], e);
            end
            checks++;
            if (busy[0] !== (n >= 2)) begin
                errors++;
                $display("FAIL cont_busy n=%0d got %b exp %b", n, busy[0], n >= 2);
            end
            checks++;
            if (done[0] !== 1'b0) begin
                errors++;
                $display("FAIL cont_done n=%0d got %b exp 0", n, done[0]);
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL cont_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_burst();
        apply_reset();
        half_per[0 +: CW] = CW'(2);
        burst[0 +: BW]    = BW'(3);
        trig[0] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (done[0] !== (n == 14)) begin
                errors++;
                $display("FAIL burst_done n=%0d got %b exp %b", n, done[0], n == 14);
            end
            if (n == 13) begin
                checks++;
                if (clk_out[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_last_high n=%0d got %b exp 1", n, clk_out[0]);
                end
            end
            if (n > 14) begin
                checks++;
                if ({busy[0], clk_out[0]} !== 2'b00) begin
                    errors++;
                    $display("FAIL burst_after n=%0d got busy=%b clk=%b exp 0/0", n, busy[0], clk_out[0]);
                end
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL burst_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_fast();
        logic e;
        for (int h = 0; h < 2; h++) begin
            apply_reset();
            half_per[2*CW +: CW] = CW'(h);
            trig[2] = 1'b1;
            for (int n = 0; n < 24; n++) begin
                tick();
                e = (n >= 2) && ((n - 2) % 2 == 1);
                checks++;
                if (clk_out[2] !== e) begin
                    errors++;
                    $display("FAIL fast_clk hp=%0d n=%0d got %b exp %b", h, n, clk_out[2], e);
                end
                checks++;
                if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                    errors++;
                    $display("FAIL fast_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
                end
            end
        end
    endtask

    task automatic test_fall_sel();
        logic e;
        apply_reset();
        fall_sel[1] = 1'b1;
        half_per[1*CW +: CW] = CW'(2);
        half_per[3*CW +: CW] = CW'(3);
        trig[1] = 1'b1;
        trig[3] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (busy[1] !== (n >= 13)) begin
                errors++;
                $display("FAIL fall_busy1 n=%0d got %b exp %b", n, busy[1], n >= 13);
            end
            e = (n >= 5) && (((n - 5) / 3) % 2 == 0);
            checks++;
            if (clk_out[3] !== e) begin
                errors++;
                $display("FAIL fall_ch3_clk n=%0d got %b exp %b", n, clk_out[3], e);
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL fall_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
            if (n == 10) trig[1] = 1'b0;
        end
    endtask

    task automatic test_disarm();
        int w;
        apply_reset();
        half_per[0 +: CW] = CW'(4);
        trig[0] = 1'b1;
        for (w = 0; w < 50 && clk_out[0] !== 1'b1; w++) tick();
        checks++;
        if (clk_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL disarm_wait_high timeout got %b exp 1", clk_out[0]);
        end
        tick();
        disarm[0] = 1'b1;
        tick();
        disarm[0] = 1'b0;
        checks++;
        if ({clk_out[0], busy[0], done[0]} !== 3'b000) begin
            errors++;
            $display("FAIL disarm_mid_high got clk/busy/done=%b exp 000", {clk_out[0], busy[0], done[0]});
        end
        trig[0] = 1'b0;
        repeat (4) tick();
        trig[0] = 1'b1;
        tick();
        tick();
        disarm[0] = 1'b1;
        tick();
        disarm[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL disarm_coincident n=%0d got busy=%b exp 0", n, busy[0]);
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL disarm_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
            tick();
        end
        apply_reset();
        for (int c = 0; c < NCH; c++) half_per[c*CW +: CW] = CW'(3);
        trig = '1;
        for (w = 0; w < 50 && clk_out[0] !== 1'b1; w++) tick();
        checks++;
        if (clk_out !== 4'hF) begin
            errors++;
            $display("FAIL rst_mid_run_pre got clk=%b exp 1111", clk_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({clk_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_run got %b/%b/%b exp all 0", clk_out, busy, done);
        end
    endtask

    task automatic test_retrig();
        logic e;
        apply_reset();
        half_per[0 +: CW] = CW'(5);
        trig[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (RETRIG && n >= 20) e = (n >= 25) && (((n - 25) / 5) % 2 == 0);
            else                   e = (n >= 7) && (((n - 7) / 5) % 2 == 0);
            checks++;
            if (clk_out[0] !== e) begin
                errors++;
                $display("FAIL retrig_clk n=%0d got %b exp %b", n, clk_out[0], e);
            end
            checks++;
            if ({busy[0], done[0]} !== {n >= 2, 1'b0}) begin
                errors++;
                $display("FAIL retrig_busy_done n=%0d got %b%b exp %b0", n, busy[0], done[0], n >= 2);
            end
            checks++;
            if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL retrig_model n=%0d got %b/%b/%b exp %b/%b/%b", n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
            end
            if (n == 9)  trig[0] = 1'b0;
            if (n == 17) trig[0] = 1'b1;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int seg = 0; seg < 6; seg++) begin
            fall_sel = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                half_per[c*CW +: CW] = CW'($urandom_range(0, 5));
                burst[c*BW +: BW]    = BW'($urandom_range(0, 3));
            end
            for (int n = 0; n < 250; n++) begin
                rst = ($urandom_range(0, 299) == 0);
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 7) == 0) trig[c] = ~trig[c];
                    disarm[c] = ($urandom_range(0, 79) == 0);
                    if ($urandom_range(0, 39) == 0) half_per[c*CW +: CW] = CW'($urandom_range(0, 5));
                    if ($urandom_range(0, 39) == 0) burst[c*BW +: BW] = BW'($urandom_range(0, 3));
                end
                tick();
                checks++;
                if ({clk_out, busy, done} !== {exp_clk, exp_busy, exp_done}) begin
                    errors++;
                    $display("FAIL random_model seg=%0d n=%0d got %b/%b/%b exp %b/%b/%b", seg, n, clk_out, busy, done, exp_clk, exp_busy, exp_done);
                end
            end
        end
        rst    = 1'b0;
        disarm = '0;
    endtask

    initial begin
        rst      = 1'b1;
        trig     = '0;
        fall_sel = '0;
        half_per = '0;
        burst    = '0;
        disarm   = '0;
        test_reset();
        test_continuous();
        test_burst();
        test_fast();
        test_fall_sel();
        test_disarm();
        test_retrig();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
